dmem_adapter: RTL and testbench

DMEM_ADAPTER -- requirements
Module: dmem_adapter

---
 rtl/dmem_pkg.sv | 60 ++++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/dmem_adapter.sv | 107 ++++++++++
 tb/tb_dmem_adapter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and load/store formatting helpers for the data-memory adapter.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [1:0] off;
        mem_size_e  size;
        logic       is_unsigned;
        logic       we;
        logic       err;
    } dmem_meta_t;

    // Misalignment, the reserved size encoding, or an address beyond the dpram all fault.
    function automatic logic req_err(input logic [31:0] addr, input logic [1:0] size,
                                     input int unsigned addrw);
        logic oor;
        oor = (addr >> addrw) != 32'd0;
        case (size)
            2'd0:    req_err = oor;
            2'd1:    req_err = oor | addr[0];
            2'd2:    req_err = oor | (addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input mem_size_e size, input logic [1:0] off);
        case (size)
            MEM_B:   store_mask = 4'b0001 << off;
            MEM_H:   store_mask = 4'b0011 << off;
            default: store_mask = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input mem_size_e size, input logic [31:0] wdata);
        case (size)
            MEM_B:   store_data = {4{wdata[7:0]}};
            MEM_H:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input mem_size_e size, input logic [1:0] off,
                                             input logic uns, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[8*off +: 8];
        h = data[16*off[1] +: 16];
        case (size)
            MEM_B:   load_fmt = uns ? {24'd0, b} : {{24{b[7]}}, b};
            MEM_H:   load_fmt = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_fmt = data;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with registered head; push and pop may coincide.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok, full;

    always_comb begin
        full    = count_q == (AW+1)'(DEPTH);
        empty_o = count_q == '0;
        push_ok = push_i && (!full || pop_i);
        pop_ok  = pop_i && !empty_o;
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        data_o  = mem_q[rptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dmem_adapter.sv
// Load/store adapter onto a one-cycle pipelined dpram, with in-order buffered responses.
module dmem_adapter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDRW      = 10,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic             req_we_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic [3:0]       mem_mask_o,
    output logic             mem_we_o,
    output logic             mem_valid_o,
    input  logic [31:0]      mem_data_i,
    input  logic             mem_resp_i
);
    localparam int unsigned CntW = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned OccW = CntW + 1;

    logic            inflight_q, inflight_d;
    dmem_meta_t      meta_q, meta_d, req_meta;
    logic            accept, pop, push;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty;
    logic [32:0]     push_data, head_data;
    logic [31:0]     load_data;
    logic [OccW-1:0] occupancy;

    always_comb begin
        pop       = rsp_valid_o && rsp_ready_i;
        // Reserve a FIFO slot for every request that could still produce a response.
        occupancy = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
        req_ready_o = rst_ni && (occupancy < OccW'(RESP_DEPTH));
        accept    = req_valid_i && req_ready_o;

        req_meta.off         = req_addr_i[1:0];
        req_meta.size        = mem_size_e'(req_size_i);
        req_meta.is_unsigned = req_unsigned_i;
        req_meta.we          = req_we_i;
        req_meta.err         = req_err(req_addr_i, req_size_i, ADDRW);

        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_mask_o  = 4'h0;
        mem_data_o  = 32'd0;
        if (accept) begin
            mem_valid_o = 1'b1;
            mem_addr_o  = {req_addr_i[ADDRW-1:2], 2'b00};
            if (!req_meta.err) begin
                mem_we_o   = req_we_i;
                mem_mask_o = store_mask(req_meta.size, req_meta.off);
                if (req_we_i) begin
                    mem_data_o = store_data(req_meta.size, req_wdata_i);
                end
            end
        end

        meta_d     = accept ? req_meta : meta_q;
        inflight_d = accept ? 1'b1 : (mem_resp_i ? 1'b0 : inflight_q);

        push      = mem_resp_i && inflight_q;
        load_data = load_fmt(meta_q.size, meta_q.off, meta_q.is_unsigned, mem_data_i);
        push_data = {meta_q.err, (meta_q.err || meta_q.we) ? 32'd0 : load_data};

        rsp_valid_o = !fifo_empty;
        rsp_err_o   = rsp_valid_o & head_data[32];
        rsp_rdata_o = rsp_valid_o ? head_data[31:0] : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            meta_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            meta_q     <= meta_d;
        end
    end

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_dmem_adapter.sv
// Directed bench for dmem_adapter with a behavioural one-cycle dpram.
module tb_dmem_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_mask_o;
    logic        mem_we_o;
    logic        mem_valid_o;
    logic [31:0] mem_data_i = '0;
    logic        mem_resp_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [1024];
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];

    always #5 clk_i = ~clk_i;

    dmem_adapter #(
        .ADDRW      (10),
        .RESP_DEPTH (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_mask_o     (mem_mask_o),
        .mem_we_o       (mem_we_o),
        .mem_valid_o    (mem_valid_o),
        .mem_data_i     (mem_data_i),
        .mem_resp_i     (mem_resp_i)
    );

    // Pipelined dpram: read data and resp one cycle after mem_valid_o, read-before-write.
    always @(posedge clk_i) begin
        mem_resp_i <= mem_valid_o;
        if (mem_valid_o) begin
            mem_data_i <= {mem[mem_addr_o + 10'd3], mem[mem_addr_o + 10'd2],
                           mem[mem_addr_o + 10'd1], mem[mem_addr_o]};
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o && mem_mask_o[b]) begin
                    mem[mem_addr_o + 10'(b)] <= mem_data_o[8*b +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
    endtask

    task automatic idle();
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
    endtask

    // Expects rsp_ready_i=1; waits a bounded number of cycles, checks, then pops.
    task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
        int n;
        n = 0;
        while (!rsp_valid_o && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata_o, rdata);
        chk({tag, "_err"}, 32'(rsp_err_o), 32'(err));
        step();
    endtask

    task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 2'd2, 1'b0, addr, data);
        step();
        idle();
        expect_rsp("st_fill", 32'd0, 1'b0);
    endtask

    initial begin
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h30; addrs[3] = 32'h40;
        exps[0] = 32'h80ADBEEF; exps[1] = 32'h11112222;
        exps[2] = 32'h33334444; exps[3] = 32'h55556666;

        // Reset state
        #2;
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready_o), 32'd1);

        // Word store then word load with latency check
        drive(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        #1;
        chk("st_w_mem_valid", 32'(mem_valid_o), 32'd1);
        chk("st_w_mem_we", 32'(mem_we_o), 32'd1);
        chk("st_w_mask", 32'(mem_mask_o), 32'hF);
        chk("st_w_data", mem_data_o, 32'hDEADBEEF);
        chk("st_w_addr", 32'(mem_addr_o), 32'h10);
        step();
        idle();
        expect_rsp("st_w", 32'd0, 1'b0);

        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        #1;
        chk("ld_w_mem_we", 32'(mem_we_o), 32'd0);
        step();
        idle();
        chk("ld_w_lat1", 32'(rsp_valid_o), 32'd0);
        step();
        chk("ld_w_lat2", 32'(rsp_valid_o), 32'd1);
        chk("ld_w_rdata", rsp_rdata_o, 32'hDEADBEEF);
        chk("ld_w_err", 32'(rsp_err_o), 32'd0);
        step();

        // Byte store 0x80 at 0x13, then signed/unsigned byte loads
        drive(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080);
        #1;
        chk("st_b_mask", 32'(mem_mask_o), 32'h8);
        chk("st_b_data", mem_data_o, 32'h80808080);
        step();
        idle();
        expect_rsp("st_b", 32'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
        step();
        idle();
        expect_rsp("ld_bs", 32'hFFFFFF80, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
        step();
        idle();
        expect_rsp("ld_bu", 32'h00000080, 1'b0);

        // Misaligned half load faults; the following half load keeps its order and data
        drive(1'b0, 2'd1, 1'b0, 32'h01, 32'd0);
        #1;
        chk("err_h_mem_valid", 32'(mem_valid_o), 32'd1);
        chk("err_h_mem_we", 32'(mem_we_o), 32'd0);
        chk("err_h_mask", 32'(mem_mask_o), 32'd0);
        step();
        drive(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
        #1;
        chk("ld_h_ready", 32'(req_ready_o), 32'd1);
        step();
        idle();
        expect_rsp("err_h", 32'd0, 1'b1);
        expect_rsp("ld_h_after", 32'hFFFF80AD, 1'b0);

        store_word(32'h20, 32'h11112222);
        store_word(32'h30, 32'h33334444);
        store_word(32'h40, 32'h55556666);

        // Back-to-back loads with rsp_ready_i=1: one accept and one response per cycle
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b0, 2'd2, 1'b0, addrs[k], 32'd0);
            else idle();
            #1;
            if (k < 4) chk("b2b_ready", 32'(req_ready_o), 32'd1);
            if (k >= 2) begin
                chk("b2b_valid", 32'(rsp_valid_o), 32'd1);
                chk("b2b_rdata", rsp_rdata_o, exps[k-2]);
            end
            step();
        end
        idle();

        // Backpressure: only RESP_DEPTH accepts, nothing lost
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'd2, 1'b0, addrs[k], 32'd0);
            #1;
            chk("bp_ready", 32'(req_ready_o), 32'(k < 2));
            chk("bp_mem_valid", 32'(mem_valid_o), 32'(k < 2));
            step();
        end
        idle();
        chk("bp_held_valid", 32'(rsp_valid_o), 32'd1);
        rsp_ready_i = 1'b1;
        expect_rsp("bp_0", exps[0], 1'b0);
        expect_rsp("bp_1", exps[1], 1'b0);
        chk("bp_drained", 32'(rsp_valid_o), 32'd0);

        // Out-of-range word load
        drive(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
        #1;
        chk("oor_mask", 32'(mem_mask_o), 32'd0);
        chk("oor_mem_we", 32'(mem_we_o), 32'd0);
        step();
        idle();
        expect_rsp("oor", 32'd0, 1'b1);

        // Reset with one response queued and one in flight
        rsp_ready_i = 1'b0;
        drive(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        step();
        drive(1'b0, 2'd2, 1'b0, 32'h30, 32'd0);
        step();
        idle();
        chk("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_rdata", rsp_rdata_o, 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_no_stale", 32'(rsp_valid_o), 32'd0);
            step();
        end
        drive(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
        step();
        idle();
        expect_rsp("post_rst", 32'h55556666, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
